// File: rtl/lsu_mem_ctrl.sv
// Load/store access controller in front of a 32-bit word memory: splits byte-addressed
// requests into one or two lane-masked word accesses and returns extended load data.
module lsu_mem_ctrl #(
    parameter int MEM_SIZE_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [31:0] WORDS = 32'(MEM_SIZE_WORDS);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  mask_q;
    logic        split_q;
    logic        err_q;
    logic [31:0] rd_lo_q;
    logic [31:0] rd_hi_q;

    // Decode of the incoming request, registered on accept.
    logic [7:0]  size_m_d;
    logic [7:0]  mask_d;
    logic        split_d;
    logic        bad_f3_d;
    logic        err_d;
    logic [31:0] word_d;
    logic [31:0] word_next_d;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size_m_d = 8'h01;
            2'b01:   size_m_d = 8'h03;
            default: size_m_d = 8'h0F;
        endcase
        mask_d      = size_m_d << req_addr[1:0];
        split_d     = |mask_d[7:4];
        word_d      = {2'b00, req_addr[31:2]};
        word_next_d = word_d + 32'd1;
        if (req_we) begin
            bad_f3_d = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            bad_f3_d = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        err_d = bad_f3_d || (word_d >= WORDS) || (split_d && (word_next_d >= WORDS));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_lo_q  <= '0;
            rd_hi_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        mask_q   <= mask_d;
                        split_q  <= split_d;
                        err_q    <= err_d;
                        rd_hi_q  <= '0;
                        state_q  <= ACC0;
                    end
                end
                ACC0: begin
                    rd_lo_q <= mem_rd_data;
                    state_q <= (split_q && !err_q) ? ACC1 : RESP;
                end
                ACC1: begin
                    rd_hi_q <= mem_rd_data;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [63:0] data64;

    // Write enable is gated by reset so an access cut short never writes on the reset edge.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        mem_byte_en = '0;
        data64      = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
        if (state_q == ACC0 && !err_q) begin
            mem_addr    = {2'b00, addr_q[31:2]};
            mem_byte_en = mask_q[3:0];
            mem_wr_data = data64[31:0];
            mem_wr_en   = we_q & rst_n;
        end else if (state_q == ACC1) begin
            mem_addr    = {2'b00, addr_q[31:2]} + 32'd1;
            mem_byte_en = mask_q[7:4];
            mem_wr_data = data64[63:32];
            mem_wr_en   = we_q & rst_n;
        end
    end

    logic [63:0] shifted;
    logic [31:0] raw;

    always_comb begin
        shifted   = {rd_hi_q, rd_lo_q} >> {addr_q[1:0], 3'b000};
        raw       = shifted[31:0];
        rsp_rdata = '0;
        if (state_q == RESP && !we_q && !err_q) begin
            case (funct3_q)
                3'b000:  rsp_rdata = {{24{raw[7]}}, raw[7:0]};
                3'b001:  rsp_rdata = {{16{raw[15]}}, raw[15:0]};
                3'b010:  rsp_rdata = raw;
                3'b100:  rsp_rdata = {24'b0, raw[7:0]};
                3'b101:  rsp_rdata = {16'b0, raw[15:0]};
                default: rsp_rdata = '0;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_err     = (state_q == RESP) && err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-level reference memory predicts every cycle's memory
// and response outputs; directed loads/stores plus literal checks of key results.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rd_data;
  logic [1:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_SIZE_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data), .dbg_state_o(dbg_state)
  );

  // ---------------- attached data memory ----------------
  logic [31:0] mem_arr [0:MEM_WORDS-1];

  always_comb begin
    mem_rd_data = '0;
    if (mem_addr < MEM_WORDS)
      for (int l = 0; l < 4; l++)
        if (mem_byte_en[l]) mem_rd_data[8*l +: 8] = mem_arr[mem_addr[7:0]][8*l +: 8];
  end

  always @(posedge clk)
    if (mem_wr_en && mem_addr < MEM_WORDS)
      for (int l = 0; l < 4; l++)
        if (mem_byte_en[l]) mem_arr[mem_addr[7:0]][8*l +: 8] <= mem_wr_data[8*l +: 8];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        ready;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        rv;
    logic [31:0] rd;
    logic        err;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [7:0]  ref_mem [0:4*MEM_WORDS-1];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_rd;
  logic        last_err;
  logic [3:0]  last_wbe;
  logic [31:0] last_wd;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single compare process: one predicted record per cycle, idle when none queued.
  always @(negedge clk) begin : cmp
    cyc_t e;
    cyc_t a;
    if (chk_en) begin
      e = '0;
      e.ready = 1'b1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      a.ready = req_ready;  a.addr = mem_addr;  a.we = mem_wr_en;  a.wd = mem_wr_data;
      a.be = mem_byte_en;   a.rv = rsp_valid;   a.rd = rsp_rdata;  a.err = rsp_err;
      check("cycle", 128'(a), 128'(e));
    end
    if (rsp_valid) begin last_rd = rsp_rdata; last_err = rsp_err; end
    if (mem_wr_en) begin last_wbe = mem_byte_en; last_wd = mem_wr_data; end
  end

  // ---------------- driver + model ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit rst_mid);
    cyc_t c0, c1, cr;
    int size, lane, n;
    bit err, split;
    longint w0, a;
    logic [31:0] ld;
    err = we ? !(f3 inside {3'b000, 3'b001, 3'b010})
             : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    w0    = longint'(addr >> 2);
    split = (int'(addr[1:0]) + size) > 4;
    if (w0 >= MEM_WORDS) err = 1'b1;
    if (split && (w0 + 1) >= MEM_WORDS) err = 1'b1;
    c0 = '0; c1 = '0; cr = '0; ld = '0;
    if (!err) begin
      c0.addr = 32'(w0);     c0.we = we;
      c1.addr = 32'(w0 + 1); c1.we = we && !rst_mid;
      for (int i = 0; i < size; i++) begin
        a    = longint'(addr) + longint'(i);
        lane = int'(a % 4);
        if ((a >> 2) == w0) begin
          c0.be[lane] = 1'b1; c0.wd[8*lane +: 8] = wd[8*i +: 8];
        end else begin
          c1.be[lane] = 1'b1; c1.wd[8*lane +: 8] = wd[8*i +: 8];
        end
        if (we) begin
          if (!rst_mid || (a >> 2) == w0) ref_mem[int'(a)] = wd[8*i +: 8];
        end else begin
          ld[8*i +: 8] = ref_mem[int'(a)];
        end
      end
      case (f3)
        3'b000:  ld = {{24{ld[7]}}, ld[7:0]};
        3'b001:  ld = {{16{ld[15]}}, ld[15:0]};
        default: ;
      endcase
      if (we) ld = '0;
    end
    cr.rv = 1'b1; cr.rd = ld; cr.err = err;

    @(negedge clk);
    last_rd = 32'hBAD0BAD0; last_err = 1'bx;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    exp_q.push_back(c0);
    if (split && !err) exp_q.push_back(c1);
    if (rst_mid) begin
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
    end else begin
      exp_q.push_back(cr);
      n = (split && !err) ? 3 : 2;
      repeat (n) @(posedge clk);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = '0;
    for (int i = 0; i < 4*MEM_WORDS; i++) ref_mem[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'(1'b1));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    check("rst_rsp_err", 128'(rsp_err), 128'(1'b0));
    check("rst_rsp_rdata", 128'(rsp_rdata), 128'(32'h0));
    check("rst_mem_we", 128'(mem_wr_en), 128'(1'b0));
    rst_n = 1'b1;
    #1 chk_en = 1'b1;

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    check("lw_10", 128'(last_rd), 128'(32'hDEADBEEF));

    do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0);
    check("sb_13_be", 128'(last_wbe), 128'(4'b1000));
    check("sb_13_wd", 128'(last_wd), 128'(32'hA5000000));
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    check("lb_13", 128'(last_rd), 128'(32'hFFFFFFA5));
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    check("lbu_13", 128'(last_rd), 128'(32'h000000A5));

    do_req(1'b1, 3'b010, 32'h06, 32'h11223344, 1'b0);
    check("sw_06_hi_be", 128'(last_wbe), 128'(4'b0011));
    check("sw_06_hi_wd", 128'(last_wd), 128'(32'h00001122));
    do_req(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
    check("lw_06", 128'(last_rd), 128'(32'h11223344));

    do_req(1'b1, 3'b010, 32'h20, 32'h80015678, 1'b0);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
    check("lh_22", 128'(last_rd), 128'(32'hFFFF8001));
    do_req(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
    check("lhu_22", 128'(last_rd), 128'(32'h00008001));
    do_req(1'b0, 3'b001, 32'h23, 32'h0, 1'b0);
    check("lh_23_split", 128'(last_rd), 128'(32'h00000080));

    do_req(1'b0, 3'b011, 32'h00, 32'h0, 1'b0);
    check("err_f3_load", 128'({last_err, last_rd}), 128'({1'b1, 32'h0}));
    do_req(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b0);
    check("err_f3_store", 128'({last_err, last_rd}), 128'({1'b1, 32'h0}));
    do_req(1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 1'b0);
    check("err_sw_400", 128'({last_err, last_rd}), 128'({1'b1, 32'h0}));
    do_req(1'b0, 3'b010, 32'h3FE, 32'h0, 1'b0);
    check("err_lw_3fe", 128'({last_err, last_rd}), 128'({1'b1, 32'h0}));
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0);
    check("lw_3fc_ok", 128'({last_err, last_rd}), 128'({1'b0, 32'h0}));

    do_req(1'b1, 3'b010, 32'h06, 32'hCAFEF00D, 1'b1);
    do_req(1'b0, 3'b010, 32'h04, 32'h0, 1'b0);
    check("rst_lo_word", 128'(last_rd), 128'(32'hF00D0000));
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    check("rst_hi_word", 128'(last_rd), 128'(32'h00001122));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
